// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered N-channel stream mux with fixed/round-robin arbitration
// Optional packet lock: define STREAM_MUX_LOCK_EN.
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
`endif
    input  logic [SELW-1:0]           s,
    input  logic                      rr,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_ch,
`ifdef STREAM_MUX_LOCK_EN
    output logic                      out_last,
`endif
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [CHANNELS-1:0] gnt;
    logic [SELW-1:0]     gnt_idx;
    logic [SELW-1:0]     ptr;
    logic                rr_hit;
    logic                can_load;
    logic                accept;

`ifdef STREAM_MUX_LOCK_EN
    logic                locked;
    logic [SELW-1:0]     lock_ch;
`endif

    assign can_load = ~out_valid | out_ready;

    always_comb begin
        gnt    = '0;
        rr_hit = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
        if (locked) begin
            gnt[lock_ch] = 1'b1;
        end else
`endif
        if (rr) begin
            // Search starts just after the last served channel and wraps.
            for (int i = 1; i <= CHANNELS; i++) begin
                if (!rr_hit && in_valid[(int'(ptr) + i) % CHANNELS]) begin
                    gnt[(int'(ptr) + i) % CHANNELS] = 1'b1;
                    rr_hit = 1'b1;
                end
            end
        end else if (int'(s) < CHANNELS) begin
            gnt[s] = 1'b1;
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (gnt[k]) begin
                gnt_idx = SELW'(k);
            end
        end
    end

    assign in_ready = (rst || !can_load) ? '0 : gnt;
    assign accept   = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(CHANNELS - 1);
`ifdef STREAM_MUX_LOCK_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            out_ch    <= gnt_idx;
            ptr       <= gnt_idx;
`ifdef STREAM_MUX_LOCK_EN
            out_last  <= in_last[gnt_idx];
            locked    <= ~in_last[gnt_idx];
            lock_ch   <= gnt_idx;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr with a rule-level reference model
module tb_stream_mux_rr;

    localparam int W  = 8;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0] in_valid;
    logic [CH-1:0] in_ready;
    logic [1:0]    s;
    logic          rr;
    logic [W-1:0]  out_data;
    logic [1:0]    out_ch;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    ready3;
    logic [W-1:0]  od3;
    logic [1:0]    oc3;
    logic          ov3;
`ifdef STREAM_MUX_LOCK_EN
    logic [CH-1:0] in_last;
    logic          out_last;
    logic          ol3;
`endif

    int checks = 0;
    int errors = 0;

    int       m_ptr, m_ch, last_acc;
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_locked, m_last;
    int       m_lock_ch;
    logic [CH-1:0] ir_seen;
    bit       dut3_chk = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .CHANNELS(CH)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_LOCK_EN
        .in_last(in_last), .out_last(out_last),
`endif
        .s(s), .rr(rr), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data[3*W-1:0]), .in_valid(in_valid[2:0]), .in_ready(ready3),
`ifdef STREAM_MUX_LOCK_EN
        .in_last(in_last[2:0]), .out_last(ol3),
`endif
        .s(s), .rr(rr), .out_data(od3), .out_ch(oc3),
        .out_valid(ov3), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = CH - 1;
        m_locked = 0; m_lock_ch = 0; m_last = 0;
    endtask

    function automatic int exp_grant();
        if (m_locked) return m_lock_ch;
        if (!rr) return (int'(s) < CH) ? int'(s) : -1;
        for (int i = 1; i <= CH; i++) begin
            if (in_valid[(m_ptr + i) % CH]) return (m_ptr + i) % CH;
        end
        return -1;
    endfunction

    task automatic cycle();
        int g;
        bit can_load;
        logic [CH-1:0] er;
        @(negedge clk);
        g = exp_grant();
        can_load = !m_valid || out_ready;
        er = '0;
        if (!rst && can_load && g >= 0) er[g] = 1'b1;
        ir_seen = in_ready;
        check("in_ready", in_ready, er);
        if (dut3_chk) check("oor_ch3_ready", ready3, 3'b000);
        last_acc = (er != 0 && in_valid[g]) ? g : -1;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (last_acc >= 0) begin
            m_valid = 1; m_data = in_data[last_acc*W +: W]; m_ch = last_acc; m_ptr = last_acc;
`ifdef STREAM_MUX_LOCK_EN
            m_last = in_last[last_acc]; m_locked = !in_last[last_acc]; m_lock_ch = last_acc;
`endif
        end else if (out_ready) begin
            m_valid = 0;
        end
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_ch", out_ch, m_ch);
`ifdef STREAM_MUX_LOCK_EN
        check("out_last", out_last, m_last);
`endif
    endtask

    task automatic set_ch(input int k, input bit v, input bit [7:0] d);
        in_valid[k] = v;
        in_data[k*W +: W] = d;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = 0; s = 0; rr = 0; out_ready = 0;
`ifdef STREAM_MUX_LOCK_EN
        in_last = '1;
`endif
        model_reset();
        cycle();
        check("reset_out_valid", out_valid, 1'b0);

        // Fixed select: ch2 wins over a valid ch0
        rst = 0; rr = 0; s = 2; out_ready = 1;
        set_ch(0, 1, 8'h11); set_ch(2, 1, 8'hA5);
        cycle();
        check("fixed_ready", ir_seen, 4'b0100);
        check("fixed_data", out_data, 8'hA5);
        check("fixed_ch", out_ch, 2);
        set_ch(2, 0, 8'h00);
        repeat (2) begin
            cycle();
            check("fixed_ch0_never", last_acc, -1);
        end

        // Round-robin fairness from reset
        rst = 1; cycle(); rst = 0;
        rr = 1; set_ch(0, 1, 8'h10); set_ch(1, 1, 8'h11); set_ch(2, 1, 8'h12); set_ch(3, 1, 8'h13);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_seq_ch", out_ch, i % CH);
            check("rr_seq_data", out_data, 8'h10 + (i % CH));
        end

        // Backpressure holds the loaded beat, release loads next beat without a gap
        rst = 1; cycle(); rst = 0;
        rr = 0; s = 1; in_valid = 0; set_ch(1, 1, 8'h3C); out_ready = 1;
        cycle();
        set_ch(1, 1, 8'h4D); out_ready = 0;
        repeat (3) begin
            cycle();
            check("bp_hold", out_data, 8'h3C);
            check("bp_ready", ir_seen, 4'b0000);
        end
        out_ready = 1;
        cycle();
        check("bp_next", out_data, 8'h4D);
        set_ch(1, 0, 8'h00);
        cycle();
        check("bp_no_dup", out_valid, 1'b0);

        // Out-of-range and idle select
        set_ch(1, 1, 8'h77); s = 1;
        cycle();
        s = 3; dut3_chk = 1;
        repeat (3) begin
            cycle();
            check("oor_no_accept", last_acc, -1);
        end
        check("oor_drained", out_valid, 1'b0);
        dut3_chk = 0;

        // Reset in the middle of a stream
        rr = 1; for (int k = 0; k < CH; k++) set_ch(k, 1, 8'h20 + 8'(k));
        repeat (2) cycle();
        rst = 1; cycle();
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_data", out_data, 8'h00);
        rst = 0; cycle();
        check("rst_mid_first", out_ch, 0);

        // Randomized traffic against the model; producers hold until accepted
        for (int n = 0; n < 400; n++) begin
            rr = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 59) == 0);
            cycle();
            for (int k = 0; k < CH; k++) begin
                if (k == last_acc || !in_valid[k]) begin
                    set_ch(k, 1'($urandom_range(0, 1)), 8'($urandom));
`ifdef STREAM_MUX_LOCK_EN
                    in_last[k] = 1'($urandom_range(0, 1));
`endif
                end
            end
        end

`ifdef STREAM_MUX_LOCK_EN
        // Packet lock: ch1 three-beat packet while ch2 stays valid
        rst = 1; cycle(); rst = 0;
        rr = 1; out_ready = 1; in_valid = 0; in_last = '1;
        set_ch(2, 1, 8'hC2);
        set_ch(1, 1, 8'hB0); in_last[1] = 0;
        cycle(); check("lock_b1", out_ch, 1);
        set_ch(1, 1, 8'hB1);
        cycle(); check("lock_b2", out_ch, 1);
        set_ch(1, 1, 8'hB2); in_last[1] = 1;
        cycle(); check("lock_b3", out_ch, 1);
        set_ch(1, 0, 8'h00);
        cycle(); check("lock_release", out_ch, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
